uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART_TX instance between up to four byte-stream requesters at packet granularity. Each granted packet goes out as a command byte {requester id, length} followed by exactly that many data bytes. This matches the command/data framing the receive-side controller decodes. Grants are round-robin, and a packet is never interleaved with another.

## Interface
- N_REQ, 4, number of requesters (2..4; the id field is 2 bits)
- LEN_W, 6, packet length width (max 63 data bytes)
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  requester i has a packet pending; held until grant[i]
- req_len  in  LEN_W*N_REQ  packed lengths; slice i is sampled on grant
- req_data  in  8*N_REQ  packed data bytes
- req_data_valid  in  N_REQ  byte on slice i is valid
- req_data_ready  out  N_REQ  byte accepted from requester i (one-hot or zero)
- grant  out  N_REQ  one-hot owner of the current packet; zero when idle
- pkt_done  out  1  one-cycle pulse when the last byte of a packet completes
- tx_dv  out  1  one-cycle start pulse to UART_TX
- tx_byte  out  8  byte to UART_TX; held from tx_dv until tx_done
- tx_done  in  1  UART_TX one-cycle completion pulse
- tx_active  in  1  UART_TX busy; used only as a start guard

## Operation
- States: IDLE, HDR, HDR_WAIT, FETCH, SEND, SEND_WAIT, DONE.
- IDLE
  - If any req_valid is set and tx_active is 0, select the winner round-robin, starting from ptr+1 mod N_REQ.
  - Register grant, latch len from req_len[winner], clear cnt, go to HDR.
- HDR
  - tx_byte = {id[1:0], len[5:0]}, tx_dv = 1 for this cycle only, go to HDR_WAIT.
- HDR_WAIT
  - Wait for tx_done.
  - Then go to DONE if cnt == len (covers len = 0), else go to FETCH.
- FETCH
  - req_data_ready[id] = 1.
  - On req_data_valid[id], latch req_data[id] into tx_byte, cnt <= cnt+1, go to SEND.
  - Stay in FETCH indefinitely while req_data_valid[id] is 0. There is no timeout.
- SEND
  - tx_dv = 1 for one cycle, go to SEND_WAIT.
- SEND_WAIT
  - On tx_done, go to DONE if cnt == len, else go to FETCH.
- DONE
  - pkt_done = 1, ptr <= id, grant <= 0, go to IDLE.
- Arithmetic: cnt and len are LEN_W-bit unsigned. cnt never exceeds len, so there is no wrap.
- Once granted, the packet completes even if req_valid[id] deasserts. The requester is committed.
- req_valid/req_data_valid from non-granted requesters are ignored; their ready stays 0.
- tx_done outside HDR_WAIT/SEND_WAIT is ignored.
- Reset value of ptr is N_REQ-1, so requester 0 wins first after reset.

## Timing
- Reset (rst = 0 at a clk edge) puts the block in IDLE. Next-cycle output values:
  - grant = 0, req_data_ready = 0, tx_dv = 0, tx_byte = 0, pkt_done = 0.
  - cnt = 0, len = 0, ptr = N_REQ-1.
- Reset mid-packet abandons the packet with no pkt_done. UART_TX shares rst, so a frame in flight is also aborted.
- Latency from req_valid seen in IDLE:
  - grant high 1 cycle later (HDR cycle).
  - tx_dv high in that same cycle.
- Data path: byte accepted in FETCH (cycle k) → tx_dv at k+1.
- Minimum gap between tx_done and the next tx_dv is 2 cycles: tx_done → FETCH (with req_data_valid already high) → SEND.
- pkt_done fires 1 cycle after the final tx_done; grant falls in the same cycle it rises.
- Earliest next grant: 2 cycles after pkt_done (DONE → IDLE → HDR).
- Simultaneous requests are resolved purely by rotation from ptr; the result is deterministic.

## Structure
- Package uart_arb_pkg holds:
  - state enum
  - ID_W = 2 and LEN_W = 6
  - header packing function make_hdr(id, len)
- Sub-module rr_arbiter (req, ptr → one-hot grant, encoded id) is combinational.
  - Used only in IDLE.
  - Reusable for the planned multi-RX merge.
- Main FSM, counters and the tx_byte register live in uart_tx_arbiter.

## Test plan
- Single packet
  - Stimulus: requester 1 sends len = 3, bytes 0xA1, 0xA2, 0xA3.
  - Expected: UART_TX sees 0x43, 0xA1, 0xA2, 0xA3 and exactly 4 tx_dv pulses; pkt_done fires once; grant = 4'b0010 throughout.
- Zero-length packet
  - Stimulus: requester 2 sends len = 0.
  - Expected: header 0x80 only; req_data_ready never asserts; pkt_done follows the header's tx_done.
- Contention
  - Stimulus: req_valid = 4'b1111 held, every len = 1.
  - Expected: grant order 0, 1, 2, 3, 0 after reset; no packet interleaving.
- Data stall
  - Stimulus: requester 0, len = 2; req_data_valid withheld 20 cycles before the second byte.
  - Expected: block holds FETCH with ready high and no tx_dv; packet completes afterwards.
- Mid-packet reset
  - Stimulus: rst = 0 during SEND_WAIT of byte 2 of 5.
  - Expected: all outputs at reset values next cycle; no pkt_done.
  - Follow-up: a fresh request after reset starts from requester 0 with a new header.
- Max length
  - Stimulus: requester 3, len = 63.
  - Expected: 64 tx_dv pulses total; header 0xFF; cnt ends at 63 with no wrap.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX packet arbiter.
// Holds the FSM state encoding, field widths and the command-byte packing.
package uart_arb_pkg;

    localparam int unsigned ID_W   = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HDR_WAIT,
        S_FETCH,
        S_SEND,
        S_SEND_WAIT,
        S_DONE
    } state_e;

    // Command byte as decoded by the receive-side controller
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } hdr_t;

    function automatic hdr_t make_hdr(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
        hdr_t h;
        h.id  = id;
        h.len = len;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after i_ptr wins.
// Returns a one-hot grant and the encoded winner id.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic [ID_W-1:0]  o_id_c
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // Scan ptr+1 .. ptr+N_REQ modulo N_REQ; ptr itself has lowest priority
    always_comb begin
        o_gnt_c = '0;
        o_id_c  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_idx = ID_W'((32'(i_ptr) + 32'(k)) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt_c[w_idx] = 1'b1;
                o_id_c         = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX among up to four requesters at packet granularity.
// Each packet is sent as a {id, len} command byte followed by len data bytes.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [LEN_W*N_REQ-1:0] req_len,
    input  logic [8*N_REQ-1:0]     req_data,
    input  logic [N_REQ-1:0]       req_data_valid,
    output logic [N_REQ-1:0]       req_data_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   pkt_done,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    input  logic                   tx_active
);

    import uart_arb_pkg::*;

    state_e            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  r_ready;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;
    logic              r_pkt_done;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_id;
    logic [LEN_W-1:0]  w_req_len;
    logic [BYTE_W-1:0] w_sel_data;
    logic              w_sel_valid;
    logic [N_REQ-1:0]  w_id_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_gnt),
        .o_id_c  (w_id)
    );

    assign w_req_len   = req_len[32'(w_id)*LEN_W +: LEN_W];
    assign w_sel_data  = req_data[32'(r_id)*BYTE_W +: BYTE_W];
    assign w_sel_valid = req_data_valid[r_id];
    assign w_id_onehot = N_REQ'(1) << r_id;

    // Outputs are presented one cycle after the decision that produces them
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_ready    <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
            r_pkt_done <= 1'b0;
            r_id       <= '0;
            r_ptr      <= ID_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_len      <= '0;
        end else begin
            r_tx_dv    <= 1'b0;
            r_pkt_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((|req_valid) && !tx_active) begin
                        r_grant   <= w_gnt;
                        r_id      <= w_id;
                        r_len     <= w_req_len;
                        r_cnt     <= '0;
                        r_tx_byte <= make_hdr(w_id, w_req_len);
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: r_state <= S_HDR_WAIT;
                S_HDR_WAIT, S_SEND_WAIT: begin
                    // cnt == len right after the header covers zero-length packets
                    if (tx_done) begin
                        if (r_cnt == r_len) begin
                            r_pkt_done <= 1'b1;
                            r_grant    <= '0;
                            r_ptr      <= r_id;
                            r_state    <= S_DONE;
                        end else begin
                            r_ready <= w_id_onehot;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_sel_valid) begin
                        r_tx_byte <= w_sel_data;
                        r_cnt     <= r_cnt + LEN_W'(1);
                        r_ready   <= '0;
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND:  r_state <= S_SEND_WAIT;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_data_ready = r_ready;
    assign grant          = r_grant;
    assign pkt_done       = r_pkt_done;
    assign tx_dv          = r_tx_dv;
    assign tx_byte        = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX and requesters.
// All observation happens on the falling edge or 2 time units after the rising edge.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LEN_W = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [LEN_W*N_REQ-1:0] req_len = '0;
    logic [8*N_REQ-1:0]     req_data = '0;
    logic [N_REQ-1:0]       req_data_valid = '0;
    logic [N_REQ-1:0]       req_data_ready;
    logic [N_REQ-1:0]       grant;
    logic                   pkt_done;
    logic                   tx_dv;
    logic [7:0]             tx_byte;
    logic                   tx_done = 1'b0;
    logic                   tx_active = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ (N_REQ),
        .LEN_W (LEN_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_data       (req_data),
        .req_data_valid (req_data_valid),
        .req_data_ready (req_data_ready),
        .grant          (grant),
        .pkt_done       (pkt_done),
        .tx_dv          (tx_dv),
        .tx_byte        (tx_byte),
        .tx_done        (tx_done),
        .tx_active      (tx_active)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester data sources and the observation log
    int               dbase [N_REQ];
    int               idx   [N_REQ];
    int               left  [N_REQ];
    logic             stall [N_REQ];
    logic             pend  [N_REQ];
    int               busy = 0;
    logic [7:0]       txq [$];
    logic [N_REQ-1:0] glog [$];
    int               dv_cnt = 0;
    int               pkt_cnt = 0;
    int               ready_seen = 0;
    int               bad = 0;
    logic [N_REQ-1:0] prev_grant = '0;

    initial begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            dbase[i] = 0; idx[i] = 0; left[i] = 0; stall[i] = 1'b0; pend[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst) begin
            busy      = 0;
            tx_active = 1'b0;
        end else begin
            if (grant != '0 && prev_grant == '0) glog.push_back(grant);
            if (grant != '0 && prev_grant != '0 && grant != prev_grant) bad++;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    tx_done   = 1'b1;
                    tx_active = 1'b0;
                end
            end
            if (tx_dv) begin
                busy      = 3;
                tx_active = 1'b1;
                txq.push_back(tx_byte);
                dv_cnt++;
                if (grant == '0) bad++;
            end
            if (req_data_ready != '0) begin
                ready_seen++;
                if (req_data_ready != grant) bad++;
            end
            if (pkt_done) pkt_cnt++;
        end
        prev_grant = grant;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!rst) pend[i] = 1'b0;
            if (pend[i]) begin
                idx[i]++;
                left[i]--;
            end
            req_data[i*8 +: 8] = 8'(dbase[i] + idx[i]);
            req_data_valid[i]  = rst && !stall[i] && (left[i] > 0);
            pend[i]            = req_data_ready[i] && req_data_valid[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        txq.delete();
        glog.delete();
        dv_cnt     = 0;
        pkt_cnt    = 0;
        ready_seen = 0;
        bad        = 0;
    endtask

    task automatic setup(input int i, input int len, input int base, input int nbytes);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
        dbase[i] = base;
        idx[i]   = 0;
        left[i]  = nbytes;
        stall[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        for (int i = 0; i < int'(N_REQ); i++) setup(i, 0, 0, 0);
        tick(2);
        rst = 1'b1;
        clear_log();
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int c = 0;
        while (grant == '0 && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(grant != '0), 1);
    endtask

    task automatic wait_dv(input string tag, input int n, input int budget);
        int c = 0;
        while (dv_cnt < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, dv_cnt, n);
    endtask

    task automatic wait_pkts(input string tag, input int n, input int budget);
        int c = 0;
        while (pkt_cnt < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, pkt_cnt, n);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_data_ready, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_pkt_done", pkt_done, 0);

        // Single packet: requester 1, three bytes
        setup(1, 3, 8'hA1, 3);
        req_valid = 4'b0010;
        tick(1);
        chk("t1_grant_lat", grant, 4'b0010);
        chk("t1_dv_lat", tx_dv, 1);
        chk("t1_hdr_lat", tx_byte, 8'h43);
        req_valid = '0;
        wait_pkts("t1_pkt", 1, 200);
        tick(3);
        chk("t1_pkt_once", pkt_cnt, 1);
        chk("t1_dv_cnt", dv_cnt, 4);
        chk("t1_b0", txq[0], 8'h43);
        chk("t1_b1", txq[1], 8'hA1);
        chk("t1_b2", txq[2], 8'hA2);
        chk("t1_b3", txq[3], 8'hA3);
        chk("t1_glog_n", glog.size(), 1);
        chk("t1_glog0", glog[0], 4'b0010);
        chk("t1_bad", bad, 0);

        // Zero-length packet: requester 2
        clear_log();
        setup(2, 0, 0, 0);
        req_valid = 4'b0100;
        wait_grant("t2_grant", 20);
        req_valid = '0;
        wait_pkts("t2_pkt", 1, 100);
        tick(3);
        chk("t2_dv_cnt", dv_cnt, 1);
        chk("t2_hdr", txq[0], 8'h80);
        chk("t2_ready_seen", ready_seen, 0);

        // Contention: all four request, one byte each, fresh pointer
        do_reset();
        for (int i = 0; i < int'(N_REQ); i++) setup(i, 1, 16 * (i + 1), 10);
        req_valid = 4'b1111;
        wait_pkts("t3_pkt", 5, 400);
        req_valid = '0;
        tick(4);
        chk("t3_glog_n", glog.size(), 5);
        chk("t3_g0", glog[0], 4'b0001);
        chk("t3_g1", glog[1], 4'b0010);
        chk("t3_g2", glog[2], 4'b0100);
        chk("t3_g3", glog[3], 4'b1000);
        chk("t3_g4", glog[4], 4'b0001);
        chk("t3_hdr3", txq[6], 8'hC1);
        chk("t3_hdr4", txq[8], 8'h01);
        chk("t3_data4", txq[9], 8'h11);
        chk("t3_bad", bad, 0);

        // Data stall before the second byte
        clear_log();
        setup(0, 2, 8'h50, 2);
        req_valid = 4'b0001;
        wait_grant("t4_grant", 20);
        req_valid = '0;
        wait_dv("t4_first", 2, 100);
        stall[0] = 1'b1;
        tick(20);
        chk("t4_ready_hold", req_data_ready, 4'b0001);
        chk("t4_no_dv", dv_cnt, 2);
        chk("t4_no_pkt", pkt_cnt, 0);
        stall[0] = 1'b0;
        wait_pkts("t4_pkt", 1, 100);
        chk("t4_b2", txq[2], 8'h51);
        chk("t4_dv_cnt", dv_cnt, 3);

        // Mid-packet reset during SEND_WAIT of byte 2 of 5
        clear_log();
        setup(2, 5, 8'h30, 5);
        req_valid = 4'b0100;
        wait_grant("t5_grant", 20);
        req_valid = '0;
        wait_dv("t5_sent2", 3, 100);
        rst = 1'b0;
        tick(1);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_ready", req_data_ready, 0);
        chk("t5_rst_dv", tx_dv, 0);
        chk("t5_rst_byte", tx_byte, 0);
        chk("t5_rst_pkt_done", pkt_done, 0);
        chk("t5_no_pkt", pkt_cnt, 0);
        do_reset();
        setup(0, 1, 8'h60, 1);
        setup(2, 1, 8'h70, 1);
        req_valid = 4'b0101;
        wait_pkts("t5_pkts", 2, 200);
        req_valid = '0;
        tick(3);
        chk("t5_g0", glog[0], 4'b0001);
        chk("t5_g1", glog[1], 4'b0100);
        chk("t5_hdr0", txq[0], 8'h01);
        chk("t5_d0", txq[1], 8'h60);
        chk("t5_hdr1", txq[2], 8'h81);
        chk("t5_d1", txq[3], 8'h70);

        // Maximum length: requester 3, 63 bytes
        clear_log();
        setup(3, 63, 0, 63);
        req_valid = 4'b1000;
        wait_grant("t6_grant", 20);
        req_valid = '0;
        wait_pkts("t6_pkt", 1, 2000);
        tick(5);
        chk("t6_dv_cnt", dv_cnt, 64);
        chk("t6_hdr", txq[0], 8'hFF);
        chk("t6_first", txq[1], 8'h00);
        chk("t6_last", txq[63], 8'h3E);
        chk("t6_bad", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
